// File: rtl/tiny45_regfile_sched.sv
// -----------------------------------------------------------------------------
// tiny45_regfile_sched
//
// Slot scheduler and arbiter for the nibble-serial tiny45 register file.
//
// A free-running 3-bit nibble counter divides time into 8-cycle slots. Each
// slot is one full 32-bit read/write pass of the register file. Slots begin
// when the counter reads 0 and end when it reads 7. Ownership of the next
// slot is decided on the clock edge where the counter reads 7, so a slot
// always spans counter values 0..7.
//
// Two requesters share the register file:
//   - core pipeline: the priority requester
//   - debug port: served when the core is idle, or when the core has won
//     STARVE_LIMIT consecutive slots while debug was waiting
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   counter           nibble index to the register file and core datapath
//   core_req          core slot request (level)
//   core_rs1/rs2/rd   core register addresses, latched at the slot boundary
//   core_wr           core slot writes rd, latched at the slot boundary
//   core_data_rd      core write nibble, forwarded live during its slot
//   core_grant        high for all 8 cycles of a core slot
//   core_done         one-cycle pulse on the last cycle of a core slot
//   dbg_req           debug slot request (level)
//   dbg_rs, dbg_rd    debug read/destination addresses (rs drives rs1)
//   dbg_wr            debug slot writes rd
//   dbg_data_rd       debug write nibble, forwarded live during its slot
//   dbg_grant         high for all 8 cycles of a debug slot
//   dbg_done          one-cycle pulse on the last cycle of a debug slot
//   rf_rs1/rs2/rd     latched addresses to the register file
//   rf_wr_en          latched write flag, constant across the slot
//   rf_data_rd        write nibble of the current owner, 0 when idle
// -----------------------------------------------------------------------------
module tiny45_regfile_sched #(
    parameter int REG_ADDR_BITS = 4,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [2:0]               counter,
    input  logic                     core_req,
    input  logic [REG_ADDR_BITS-1:0] core_rs1,
    input  logic [REG_ADDR_BITS-1:0] core_rs2,
    input  logic [REG_ADDR_BITS-1:0] core_rd,
    input  logic                     core_wr,
    input  logic [3:0]               core_data_rd,
    output logic                     core_grant,
    output logic                     core_done,
    input  logic                     dbg_req,
    input  logic [REG_ADDR_BITS-1:0] dbg_rs,
    input  logic [REG_ADDR_BITS-1:0] dbg_rd,
    input  logic                     dbg_wr,
    input  logic [3:0]               dbg_data_rd,
    output logic                     dbg_grant,
    output logic                     dbg_done,
    output logic [REG_ADDR_BITS-1:0] rf_rs1,
    output logic [REG_ADDR_BITS-1:0] rf_rs2,
    output logic [REG_ADDR_BITS-1:0] rf_rd,
    output logic                     rf_wr_en,
    output logic [3:0]               rf_data_rd
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [3:0]               STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [REG_ADDR_BITS-1:0] ADDR_ZERO  = {REG_ADDR_BITS{1'b0}};

    // Registered state
    logic [2:0]               counter_r;
    owner_t                   owner_r;
    logic [3:0]               starve_cnt_r;
    logic [REG_ADDR_BITS-1:0] rs1_r;
    logic [REG_ADDR_BITS-1:0] rs2_r;
    logic [REG_ADDR_BITS-1:0] rd_r;
    logic                     wr_r;
    logic                     core_grant_r;
    logic                     dbg_grant_r;
    logic                     core_done_r;
    logic                     dbg_done_r;

    // Combinational helpers
    logic                     boundary_s;
    logic                     pre_boundary_s;
    logic                     starve_hit_s;
    logic                     dbg_wins_s;
    logic                     core_wins_s;
    logic [3:0]               starve_next_s;
    logic [3:0]               data_mux_s;

    assign boundary_s     = (counter_r == 3'd7);
    assign pre_boundary_s = (counter_r == 3'd6);
    assign starve_hit_s   = (starve_cnt_r == STARVE_MAX);

    // Arbitration decision and next starvation count for the coming boundary
    always_comb begin
        dbg_wins_s    = 1'b0;
        core_wins_s   = 1'b0;
        starve_next_s = 4'd0;
        if (dbg_req && (!core_req || starve_hit_s)) begin
            dbg_wins_s = 1'b1;
        end else if (core_req) begin
            core_wins_s = 1'b1;
        end else begin
            dbg_wins_s  = 1'b0;
            core_wins_s = 1'b0;
        end
        // Only a core win while debug waits accumulates; everything else clears
        if (core_wins_s && dbg_req) begin
            if (starve_hit_s) begin
                starve_next_s = starve_cnt_r;
            end else begin
                starve_next_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_next_s = 4'd0;
        end
    end

    // Free-running nibble counter; never stalls because the register file
    // rotation is locked to it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_r <= 3'd0;
        end else begin
            counter_r <= counter_r + 3'd1;
        end
    end

    // Slot owner FSM: ownership, grants and latched operands change only at
    // the slot boundary, so every slot is a full 0..7 pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r      <= OWN_NONE;
            starve_cnt_r <= 4'd0;
            rs1_r        <= ADDR_ZERO;
            rs2_r        <= ADDR_ZERO;
            rd_r         <= ADDR_ZERO;
            wr_r         <= 1'b0;
            core_grant_r <= 1'b0;
            dbg_grant_r  <= 1'b0;
        end else if (boundary_s) begin
            starve_cnt_r <= starve_next_s;
            if (dbg_wins_s) begin
                owner_r      <= OWN_DBG;
                rs1_r        <= dbg_rs;
                rs2_r        <= ADDR_ZERO;
                rd_r         <= dbg_rd;
                wr_r         <= dbg_wr;
                core_grant_r <= 1'b0;
                dbg_grant_r  <= 1'b1;
            end else if (core_wins_s) begin
                owner_r      <= OWN_CORE;
                rs1_r        <= core_rs1;
                rs2_r        <= core_rs2;
                rd_r         <= core_rd;
                wr_r         <= core_wr;
                core_grant_r <= 1'b1;
                dbg_grant_r  <= 1'b0;
            end else begin
                // Idle slot: drive zeros so the register file sees no write
                owner_r      <= OWN_NONE;
                rs1_r        <= ADDR_ZERO;
                rs2_r        <= ADDR_ZERO;
                rd_r         <= ADDR_ZERO;
                wr_r         <= 1'b0;
                core_grant_r <= 1'b0;
                dbg_grant_r  <= 1'b0;
            end
        end else begin
            owner_r      <= owner_r;
            starve_cnt_r <= starve_cnt_r;
            rs1_r        <= rs1_r;
            rs2_r        <= rs2_r;
            rd_r         <= rd_r;
            wr_r         <= wr_r;
            core_grant_r <= core_grant_r;
            dbg_grant_r  <= dbg_grant_r;
        end
    end

    // Done pulses are set one edge early (counter 6 -> 7) so they are
    // registered yet still coincide with the last cycle of the slot; the
    // owner cannot change on that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done_r <= 1'b0;
            dbg_done_r  <= 1'b0;
        end else if (pre_boundary_s) begin
            core_done_r <= (owner_r == OWN_CORE);
            dbg_done_r  <= (owner_r == OWN_DBG);
        end else begin
            core_done_r <= 1'b0;
            dbg_done_r  <= 1'b0;
        end
    end

    // Write nibble mux: the owner's data passes straight through so the
    // register file sees it in the same cycle the requester drives it
    always_comb begin
        data_mux_s = 4'd0;
        case (owner_r)
            OWN_CORE: data_mux_s = core_data_rd;
            OWN_DBG:  data_mux_s = dbg_data_rd;
            OWN_NONE: data_mux_s = 4'd0;
            default:  data_mux_s = 4'd0;
        endcase
    end

    assign counter    = counter_r;
    assign core_grant = core_grant_r;
    assign dbg_grant  = dbg_grant_r;
    assign core_done  = core_done_r;
    assign dbg_done   = dbg_done_r;
    assign rf_rs1     = rs1_r;
    assign rf_rs2     = rs2_r;
    assign rf_rd      = rd_r;
    assign rf_wr_en   = wr_r;
    assign rf_data_rd = data_mux_s;

endmodule

// File: tb/tb_tiny45_regfile_sched.sv
// -----------------------------------------------------------------------------
// tb_tiny45_regfile_sched
//
// Self-checking bench for tiny45_regfile_sched. A slot-level reference model
// (cycle position, slot owner, latched operands, starvation count) advances on
// every rising edge; inputs change and outputs are sampled near the falling
// edge. Directed scenarios are followed by a randomized run against the model.
// -----------------------------------------------------------------------------
module tb_tiny45_regfile_sched;

    localparam int AW  = 4;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    counter;
    logic          core_req;
    logic [AW-1:0] core_rs1, core_rs2, core_rd;
    logic          core_wr;
    logic [3:0]    core_data_rd;
    logic          core_grant, core_done;
    logic          dbg_req;
    logic [AW-1:0] dbg_rs, dbg_rd;
    logic          dbg_wr;
    logic [3:0]    dbg_data_rd;
    logic          dbg_grant, dbg_done;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
    logic          rf_wr_en;
    logic [3:0]    rf_data_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0 = none, 1 = core, 2 = debug
    int            m_cnt;
    int            m_owner;
    int            m_starve;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    logic          m_wr;

    tiny45_regfile_sched #(.REG_ADDR_BITS(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .core_req(core_req), .core_rs1(core_rs1), .core_rs2(core_rs2),
        .core_rd(core_rd), .core_wr(core_wr), .core_data_rd(core_data_rd),
        .core_grant(core_grant), .core_done(core_done),
        .dbg_req(dbg_req), .dbg_rs(dbg_rs), .dbg_rd(dbg_rd), .dbg_wr(dbg_wr),
        .dbg_data_rd(dbg_data_rd), .dbg_grant(dbg_grant), .dbg_done(dbg_done),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_wr_en(rf_wr_en), .rf_data_rd(rf_data_rd)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_owner = 0; m_starve = 0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wr = 1'b0;
    endtask

    // One clock: advance the model on the rising edge, return at falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_cnt == 7) begin
                if (dbg_req && (!core_req || m_starve == LIM)) begin
                    m_owner = 2; m_rs1 = dbg_rs; m_rs2 = '0; m_rd = dbg_rd;
                    m_wr = dbg_wr; m_starve = 0;
                end else if (core_req) begin
                    m_owner = 1; m_rs1 = core_rs1; m_rs2 = core_rs2;
                    m_rd = core_rd; m_wr = core_wr;
                    m_starve = dbg_req ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
                end else begin
                    m_owner = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
                    m_wr = 1'b0; m_starve = 0;
                end
            end
            m_cnt = (m_cnt + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic drive_idle();
        core_req = 1'b0; core_rs1 = '0; core_rs2 = '0; core_rd = '0;
        core_wr = 1'b0; core_data_rd = 4'd0;
        dbg_req = 1'b0; dbg_rs = '0; dbg_rd = '0; dbg_wr = 1'b0;
        dbg_data_rd = 4'd0;
    endtask

    // Bounded wait for a counter value; timing out is a failed comparison
    task automatic wait_counter(input int k);
        int n = 0;
        while (counter !== 3'(k) && n < 16) begin
            cycle();
            n++;
        end
        n_checks++;
        if (counter !== 3'(k)) begin
            n_fail++;
            $display("FAIL wait_counter: counter=%0d required %0d", counter, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (counter !== 3'd0 || core_grant !== 1'b0 || dbg_grant !== 1'b0 ||
            rf_wr_en !== 1'b0 || rf_rd !== 4'd0 || rf_rs1 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: counter=%0d cg=%b dg=%b we=%b rd=%0d rs1=%0d required all 0",
                     counter, core_grant, dbg_grant, rf_wr_en, rf_rd, rf_rs1);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_checks++;
            if (counter !== 3'((i + 1) % 8)) begin
                n_fail++;
                $display("FAIL idle_counter: counter=%0d required %0d", counter, (i + 1) % 8);
            end
            n_checks++;
            if (core_grant !== 1'b0 || dbg_grant !== 1'b0 || core_done !== 1'b0 ||
                dbg_done !== 1'b0 || rf_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs: cg=%b dg=%b cd=%b dd=%b we=%b required 0",
                         core_grant, dbg_grant, core_done, dbg_done, rf_wr_en);
            end
        end
    endtask

    task automatic test_core_slot();
        int lat = 0;
        drive_idle();
        wait_counter(3);
        core_req = 1'b1; core_rs1 = 4'd5; core_rs2 = 4'd6; core_rd = 4'd7; core_wr = 1'b1;
        while (core_grant !== 1'b1 && lat < 16) begin
            cycle();
            lat++;
        end
        n_checks++;
        if (lat != 5 || counter !== 3'd0) begin
            n_fail++;
            $display("FAIL core_latency: cycles=%0d counter=%0d required 5 and 0", lat, counter);
        end
        core_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // Operands change after latching and must be ignored
            core_rs1 = 4'($urandom); core_rd = 4'($urandom); core_wr = 1'($urandom);
            core_data_rd = 4'($urandom); dbg_data_rd = 4'($urandom);
            #1;
            n_checks++;
            if (core_grant !== 1'b1 || rf_rs1 !== 4'd5 || rf_rs2 !== 4'd6 ||
                rf_rd !== 4'd7 || rf_wr_en !== 1'b1 || counter !== 3'(i)) begin
                n_fail++;
                $display("FAIL core_slot_fields: cyc=%0d cg=%b rs1=%0d rs2=%0d rd=%0d we=%b cnt=%0d required 1/5/6/7/1/%0d",
                         i, core_grant, rf_rs1, rf_rs2, rf_rd, rf_wr_en, counter, i);
            end
            n_checks++;
            if (rf_data_rd !== core_data_rd || core_done !== (i == 7)) begin
                n_fail++;
                $display("FAIL core_slot_data: cyc=%0d data=%h done=%b required %h/%b",
                         i, rf_data_rd, core_done, core_data_rd, (i == 7));
            end
            cycle();
        end
        n_checks++;
        if (core_grant !== 1'b0 || rf_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL core_slot_end: cg=%b we=%b required 0", core_grant, rf_wr_en);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_core;
        drive_idle();
        wait_counter(7);
        core_req = 1'b1; dbg_req = 1'b1;
        core_wr = 1'b1; dbg_wr = 1'b0;
        core_rd = 4'd2; dbg_rd = 4'd11; dbg_rs = 4'd4;
        for (int s = 0; s < 7; s++) begin
            exp_core = (s % 5) != 4;
            for (int i = 0; i < 8; i++) begin
                cycle();
                n_checks++;
                if (core_grant !== exp_core || dbg_grant !== !exp_core) begin
                    n_fail++;
                    $display("FAIL b2b_owner: slot=%0d cyc=%0d cg=%b dg=%b required %b/%b",
                             s, i, core_grant, dbg_grant, exp_core, !exp_core);
                end
                if (i == 7) begin
                    n_checks++;
                    if (core_done !== exp_core || dbg_done !== !exp_core) begin
                        n_fail++;
                        $display("FAIL b2b_done: slot=%0d cd=%b dd=%b required %b/%b",
                                 s, core_done, dbg_done, exp_core, !exp_core);
                    end
                end
            end
        end
        drive_idle();
        cycle();
        n_checks++;
        if (core_grant !== 1'b0 || dbg_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: cg=%b dg=%b required 0", core_grant, dbg_grant);
        end
    endtask

    task automatic test_dbg_slot();
        int lat = 0;
        int dones = 0;
        logic [AW-1:0] rd_exp;
        drive_idle();
        core_rs1 = 4'd3; core_rs2 = 4'd12; core_rd = 4'd1;
        repeat ($urandom_range(0, 7)) cycle();
        rd_exp = 4'($urandom);
        dbg_req = 1'b1; dbg_rs = 4'd9; dbg_rd = rd_exp; dbg_wr = 1'b0;
        while (dbg_grant !== 1'b1 && lat < 16) begin
            cycle();
            lat++;
        end
        n_checks++;
        if (dbg_grant !== 1'b1 || counter !== 3'd0 || lat > 8) begin
            n_fail++;
            $display("FAIL dbg_grant: dg=%b counter=%0d cycles=%0d required 1/0/<=8",
                     dbg_grant, counter, lat);
        end
        dbg_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dbg_data_rd = 4'($urandom); core_data_rd = 4'($urandom);
            #1;
            if (dbg_done === 1'b1) dones++;
            n_checks++;
            if (dbg_grant !== 1'b1 || core_grant !== 1'b0 || rf_rs1 !== 4'd9 ||
                rf_rs2 !== 4'd0 || rf_rd !== rd_exp || rf_wr_en !== 1'b0 ||
                rf_data_rd !== dbg_data_rd) begin
                n_fail++;
                $display("FAIL dbg_slot: cyc=%0d dg=%b cg=%b rs1=%0d rs2=%0d rd=%0d we=%b data=%h required 1/0/9/0/%0d/0/%h",
                         i, dbg_grant, core_grant, rf_rs1, rf_rs2, rf_rd, rf_wr_en,
                         rf_data_rd, rd_exp, dbg_data_rd);
            end
            cycle();
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL dbg_done_count: pulses=%0d required 1", dones);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dbg_grant !== 1'b0 || dbg_done !== 1'b0 || rf_rs1 !== 4'd0) begin
                n_fail++;
                $display("FAIL dbg_after: dg=%b dd=%b rs1=%0d required 0", dbg_grant, dbg_done, rf_rs1);
            end
            cycle();
        end
    endtask

    task automatic test_withdraw();
        drive_idle();
        wait_counter(2);
        core_req = 1'b1; core_rd = 4'd8; core_wr = 1'b1;
        wait_counter(5);
        core_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_checks++;
            if (core_grant !== 1'b0 || core_done !== 1'b0 || rf_wr_en !== 1'b0 || rf_rd !== 4'd0) begin
                n_fail++;
                $display("FAIL withdraw: cg=%b cd=%b we=%b rd=%0d required 0",
                         core_grant, core_done, rf_wr_en, rf_rd);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        int lat = 0;
        drive_idle();
        core_req = 1'b1; core_rd = 4'd3; core_wr = 1'b1;
        wait_counter(0);
        wait_counter(4);
        n_checks++;
        if (core_grant !== 1'b1 || rf_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_slot: cg=%b we=%b required 1/1", core_grant, rf_wr_en);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (counter !== 3'd0 || core_grant !== 1'b0 || rf_wr_en !== 1'b0 || core_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cnt=%0d cg=%b we=%b cd=%b required 0",
                     counter, core_grant, rf_wr_en, core_done);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (core_done !== 1'b0 || counter !== 3'd0) begin
                n_fail++;
                $display("FAIL held_reset: cd=%b cnt=%0d required 0", core_done, counter);
            end
        end
        rst = 1'b0;
        while (core_grant !== 1'b1 && lat < 16) begin
            cycle();
            lat++;
        end
        n_checks++;
        if (lat != 8 || counter !== 3'd0 || rf_rd !== 4'd3) begin
            n_fail++;
            $display("FAIL resume_after_reset: cycles=%0d cnt=%0d rd=%0d required 8/0/3",
                     lat, counter, rf_rd);
        end
        drive_idle();
        repeat (8) cycle();
    endtask

    task automatic test_random();
        logic [3:0] exp_data;
        for (int i = 0; i < 800; i++) begin
            core_req = ($urandom % 4) != 0;
            dbg_req  = ($urandom % 3) == 0;
            core_rs1 = 4'($urandom); core_rs2 = 4'($urandom); core_rd = 4'($urandom);
            core_wr  = 1'($urandom); core_data_rd = 4'($urandom);
            dbg_rs   = 4'($urandom); dbg_rd = 4'($urandom);
            dbg_wr   = 1'($urandom); dbg_data_rd = 4'($urandom);
            #1;
            exp_data = (m_owner == 1) ? core_data_rd : (m_owner == 2) ? dbg_data_rd : 4'd0;
            n_checks++;
            if (counter !== 3'(m_cnt) || core_grant !== (m_owner == 1) ||
                dbg_grant !== (m_owner == 2) ||
                core_done !== (m_owner == 1 && m_cnt == 7) ||
                dbg_done !== (m_owner == 2 && m_cnt == 7)) begin
                n_fail++;
                $display("FAIL rand_ctrl: i=%0d cnt=%0d cg=%b dg=%b cd=%b dd=%b required cnt=%0d owner=%0d",
                         i, counter, core_grant, dbg_grant, core_done, dbg_done, m_cnt, m_owner);
            end
            n_checks++;
            if (rf_rs1 !== m_rs1 || rf_rs2 !== m_rs2 || rf_rd !== m_rd ||
                rf_wr_en !== m_wr || rf_data_rd !== exp_data) begin
                n_fail++;
                $display("FAIL rand_rf: i=%0d rs1=%0d rs2=%0d rd=%0d we=%b data=%h required %0d/%0d/%0d/%b/%h",
                         i, rf_rs1, rf_rs2, rf_rd, rf_wr_en, rf_data_rd,
                         m_rs1, m_rs2, m_rd, m_wr, exp_data);
            end
            cycle();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_core_slot();
        test_back_to_back();
        test_dbg_slot();
        test_withdraw();
        test_reset_mid_slot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
